// File: rtl/uart_tx_pixel_sender_if.sv
`default_nettype none
//==============================================================================
// Module      : uart_tx_pixel_sender_if
// Description : Pixel handshake bundle between a pixel source and the UART
//               pixel sender. Source drives rgb_data/pixel_valid, sender
//               answers with pixel_ready.
// Revision    : 1.0 - initial release
//==============================================================================
interface uart_tx_pixel_sender_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [3*DATA_WIDTH-1:0] rgb_data;
    logic                    pixel_valid;
    logic                    pixel_ready;

    modport master (
        output rgb_data,
        output pixel_valid,
        input  pixel_ready
    );

    modport slave (
        input  rgb_data,
        input  pixel_valid,
        output pixel_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_pixel_sender.sv
`default_nettype none
//==============================================================================
// Module      : uart_tx_pixel_sender
// Description : Accepts one RGB pixel per valid/ready handshake and sends it
//               as three 8N1 UART bytes (R, G, B) back to back. Counts pixels
//               per frame and pulses pixel_done / frame_done on completion.
// Revision    : 1.0 - initial release
//==============================================================================
module uart_tx_pixel_sender #(
    parameter int DATA_WIDTH      = 8,
    parameter int CLK_FREQ        = 100_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int BAUD_DIV        = CLK_FREQ / BAUD_RATE,
    parameter int IMG_WIDTH       = 170,
    parameter int IMG_HEIGHT      = 240,
    parameter int TOTAL_PIXELS    = IMG_WIDTH * IMG_HEIGHT,
    parameter int PIXEL_CNT_WIDTH = $clog2(TOTAL_PIXELS)
) (
    input  wire                        clk,
    input  wire                        reset,
    uart_tx_pixel_sender_if.slave      pix,
    output logic                       tx,
    output logic                       tx_busy,
    output logic                       pixel_done,
    output logic [PIXEL_CNT_WIDTH-1:0] pixel_cnt,
    output logic                       frame_done
);

    localparam int c_baud_w = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int c_bit_w  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [c_baud_w-1:0]        c_baud_last  = c_baud_w'(BAUD_DIV - 1);
    localparam logic [c_bit_w-1:0]         c_bit_last   = c_bit_w'(DATA_WIDTH - 1);
    localparam logic [1:0]                 c_last_byte  = 2'd2;
    localparam logic [PIXEL_CNT_WIDTH-1:0] c_last_pixel = PIXEL_CNT_WIDTH'(TOTAL_PIXELS - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [c_baud_w-1:0]     r_baud_cnt;
    logic [c_baud_w-1:0]     w_baud_nxt;
    logic [c_bit_w-1:0]      r_bit_idx;
    logic [c_bit_w-1:0]      w_bit_nxt;
    logic [1:0]              r_byte_idx;
    logic [1:0]              w_byte_nxt;
    logic [3*DATA_WIDTH-1:0] r_shift;
    logic [3*DATA_WIDTH-1:0] w_shift_nxt;
    logic [DATA_WIDTH-1:0]   w_byte_sel;
    logic                    w_baud_end;
    logic                    w_pixel_end;
    logic                    w_tx_nxt;
    logic                    r_tx;
    logic                    r_pixel_done;
    logic                    r_frame_done;
    logic [PIXEL_CNT_WIDTH-1:0] r_pixel_cnt;

    assign w_baud_end      = (r_baud_cnt == c_baud_last);
    assign pix.pixel_ready = (r_state == c_st_idle);
    assign tx_busy         = (r_state != c_st_idle);
    assign tx              = r_tx;
    assign pixel_done      = r_pixel_done;
    assign frame_done      = r_frame_done;
    assign pixel_cnt       = r_pixel_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and shift-register updates; baud counter restarts on every state change
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_idx;
        w_byte_nxt  = r_byte_idx;
        w_shift_nxt = r_shift;
        w_pixel_end = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_baud_nxt = '0;
                if (pix.pixel_valid) begin
                    w_state_nxt = c_st_start;
                    w_shift_nxt = pix.rgb_data;
                    w_bit_nxt   = '0;
                    w_byte_nxt  = 2'd0;
                end
            end
            c_st_start: begin
                if (w_baud_end) begin
                    w_state_nxt = c_st_data;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            c_st_data: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == c_bit_last) begin
                        w_state_nxt = c_st_stop;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            c_st_stop: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_byte_idx == c_last_byte) begin
                        w_state_nxt = c_st_idle;
                        w_pixel_end = 1'b1;
                    end else begin
                        w_state_nxt = c_st_start;
                        w_byte_nxt  = r_byte_idx + 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_baud_nxt  = '0;
            end
        endcase
    end

    // Line level for the coming cycle, so tx itself can be a plain register
    always_comb begin
        w_byte_sel = w_shift_nxt[DATA_WIDTH-1:0];
        w_tx_nxt   = 1'b1;
        case (w_byte_nxt)
            2'd0:    w_byte_sel = w_shift_nxt[3*DATA_WIDTH-1:2*DATA_WIDTH];
            2'd1:    w_byte_sel = w_shift_nxt[2*DATA_WIDTH-1:DATA_WIDTH];
            default: w_byte_sel = w_shift_nxt[DATA_WIDTH-1:0];
        endcase
        case (w_state_nxt)
            c_st_start: w_tx_nxt = 1'b0;
            c_st_data:  w_tx_nxt = w_byte_sel[w_bit_nxt];
            default:    w_tx_nxt = 1'b1;
        endcase
    end

    // Datapath registers, completion pulses and per-frame pixel counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= 2'd0;
            r_shift      <= '0;
            r_tx         <= 1'b1;
            r_pixel_done <= 1'b0;
            r_frame_done <= 1'b0;
            r_pixel_cnt  <= '0;
        end else begin
            r_baud_cnt   <= w_baud_nxt;
            r_bit_idx    <= w_bit_nxt;
            r_byte_idx   <= w_byte_nxt;
            r_shift      <= w_shift_nxt;
            r_tx         <= w_tx_nxt;
            r_pixel_done <= w_pixel_end;
            r_frame_done <= w_pixel_end && (r_pixel_cnt == c_last_pixel);
            if (w_pixel_end) begin
                if (r_pixel_cnt == c_last_pixel) begin
                    r_pixel_cnt <= '0;
                end else begin
                    r_pixel_cnt <= r_pixel_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_pixel_sender.sv
`default_nettype none
//==============================================================================
// Module      : tb_uart_tx_pixel_sender
// Description : Self-checking bench for uart_tx_pixel_sender with a UART
//               receiver model feeding a pixel scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_uart_tx_pixel_sender;

    localparam int c_bd       = 4;
    localparam int c_pix_cyc  = 30 * c_bd + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx;
    logic       tx_busy;
    logic       pixel_done;
    logic       frame_done;
    logic [1:0] pixel_cnt;

    uart_tx_pixel_sender_if #(.DATA_WIDTH(8)) pif ();

    uart_tx_pixel_sender #(
        .DATA_WIDTH (8),
        .CLK_FREQ   (400),
        .BAUD_RATE  (100),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix        (pif),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .pixel_done (pixel_done),
        .pixel_cnt  (pixel_cnt),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cyc;
        logic       fd;
        logic [1:0] cnt;
    } done_t;

    logic [23:0] exp_q[$];
    logic [23:0] rx_q[$];
    done_t       done_q[$];
    int          acc_cnt  = 0;
    int          stray_fd = 0;

    // Completion / acceptance monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (pixel_done === 1'b1) done_q.push_back('{cyc, frame_done, pixel_cnt});
            else if (frame_done !== 1'b0) stray_fd <= stray_fd + 1;
            if (pif.pixel_valid === 1'b1 && pif.pixel_ready === 1'b1) acc_cnt <= acc_cnt + 1;
        end
    end

    // Receiver model: mid-bit sampling, reassembles R,G,B into pixels
    logic        rx_prev = 1'b1;
    logic        rx_active = 1'b0;
    int          rx_n = 0;
    logic [7:0]  rx_byte = '0;
    logic [15:0] rx_hold = '0;
    int          rx_bytes = 0;
    int          rx_pix_total = 0;
    int          rx_frame_cnt = 0;
    int          rx_stop_err = 0;

    always @(negedge clk) begin
        if (reset) begin
            rx_prev      <= 1'b1;
            rx_active    <= 1'b0;
            rx_bytes     <= 0;
            rx_pix_total <= 0;
            rx_frame_cnt <= 0;
        end else begin
            rx_prev <= tx;
            if (!rx_active) begin
                if (rx_prev === 1'b1 && tx === 1'b0) begin
                    rx_active <= 1'b1;
                    rx_n      <= 0;
                end
            end else begin
                rx_n <= rx_n + 1;
                if (rx_n + 1 >= 6 && rx_n + 1 <= 34 && ((rx_n + 1 - 6) % 4) == 0)
                    rx_byte[(rx_n + 1 - 6) / 4] <= tx;
                if (rx_n + 1 == 38) begin
                    rx_active <= 1'b0;
                    if (tx !== 1'b1) rx_stop_err <= rx_stop_err + 1;
                    if (rx_bytes == 2) begin
                        rx_q.push_back({rx_hold, rx_byte});
                        rx_bytes     <= 0;
                        rx_pix_total <= rx_pix_total + 1;
                        if (rx_pix_total % 4 == 3) rx_frame_cnt <= rx_frame_cnt + 1;
                    end else begin
                        rx_hold  <= {rx_hold[7:0], rx_byte};
                        rx_bytes <= rx_bytes + 1;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pif.pixel_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        rx_q.delete();
        done_q.delete();
    endtask

    task automatic send_pixel(input logic [23:0] d, output int k);
        int t;
        @(negedge clk);
        pif.rgb_data    = d;
        pif.pixel_valid = 1'b1;
        t = 0;
        while (pif.pixel_ready !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 400) begin
            errors++;
            $display("FAIL accept_timeout: pixel_ready=%b, expected 1 within 400 cycles", pif.pixel_ready);
        end
        k = cyc;
        exp_q.push_back(d);
        @(posedge clk);
        #1;
        pif.pixel_valid = 1'b0;
        pif.rgb_data    = 24'($urandom);
    endtask

    task automatic watch_pixel(input string name, input int k, input logic [23:0] d,
                               input logic [1:0] exp_cnt);
        int   bad_tx = 0;
        int   bad_hs = 0;
        int   first = -1;
        int   b;
        int   p;
        logic eb;
        for (int j = 1; j <= 120; j++) begin
            @(negedge clk);
            b = (j - 1) / 40;
            p = ((j - 1) % 40) / 4;
            if (p == 0)      eb = 1'b0;
            else if (p == 9) eb = 1'b1;
            else             eb = d[(2 - b) * 8 + p - 1];
            if (tx !== eb) begin
                bad_tx++;
                if (first < 0) first = j;
            end
            if (pif.pixel_ready !== 1'b0 || tx_busy !== 1'b1 || pixel_done !== 1'b0) bad_hs++;
        end
        checks++;
        if (bad_tx != 0) begin
            errors++;
            $display("FAIL %s_tx_wave: %0d wrong cycles (first at k+%0d), expected 0", name, bad_tx, first);
        end
        checks++;
        if (bad_hs != 0) begin
            errors++;
            $display("FAIL %s_busy_flags: %0d wrong cycles, expected ready=0 busy=1 done=0", name, bad_hs);
        end
        @(negedge clk);
        checks++;
        if (pif.pixel_ready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_k121: ready=%b busy=%b, expected 1/0", name, pif.pixel_ready, tx_busy);
        end
        checks++;
        if (pixel_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_k121: got %b, expected 1", name, pixel_done);
        end
        checks++;
        if (pixel_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s_cnt: got %0d, expected %0d", name, pixel_cnt, exp_cnt);
        end
        @(negedge clk);
        checks++;
        if (pixel_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: got %b one cycle later, expected 0", name, pixel_done);
        end
    endtask

    task automatic check_rx(input string name, input int n);
        int          t = 0;
        logic [23:0] e;
        logic [23:0] r;
        while (rx_q.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rx_q.size() != n) begin
            errors++;
            $display("FAIL %s_rx_count: got %0d pixels, expected %0d", name, rx_q.size(), n);
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL %s_rx_data: got %h, expected %h", name, r, e);
            end
        end
        exp_q.delete();
        rx_q.delete();
        checks++;
        if (rx_stop_err != 0) begin
            errors++;
            $display("FAIL %s_stop_bits: %0d bad stop bits, expected 0", name, rx_stop_err);
        end
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (done_q.size() < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_q.size() < n) begin
            errors++;
            $display("FAIL done_timeout: got %0d pixel_done pulses, expected %0d", done_q.size(), n);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        reset = 1'b1;
        pif.pixel_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, expected 1", tx); end
        checks++;
        if (pif.pixel_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", pif.pixel_ready); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", tx_busy); end
        checks++;
        if (pixel_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d, expected 0", pixel_cnt); end
        checks++;
        if (pixel_done !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: pixel_done=%b frame_done=%b, expected 0/0", pixel_done, frame_done);
        end
        reset = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || pixel_done !== 1'b0 || pif.pixel_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_after_reset: %0d bad cycles, expected 0", bad); end
        done_q.delete();
    endtask

    task automatic test_single();
        int k;
        send_pixel(24'hA53C0F, k);
        watch_pixel("single", k, 24'hA53C0F, 2'd1);
        check_rx("single", 1);
    endtask

    task automatic test_ignore_busy();
        int    k;
        int    a0;
        done_t e;
        done_q.delete();
        a0 = acc_cnt;
        send_pixel(24'h123456, k);
        repeat (100) begin
            @(negedge clk);
            pif.rgb_data    = 24'($urandom);
            pif.pixel_valid = 1'($urandom_range(0, 1));
        end
        pif.pixel_valid = 1'b0;
        wait_done(1);
        if (done_q.size() > 0) begin
            e = done_q.pop_front();
            checks++;
            if (e.cyc != k + c_pix_cyc) begin errors++; $display("FAIL busy_done_cycle: got k+%0d, expected k+%0d", e.cyc - k, c_pix_cyc); end
            checks++;
            if (e.cnt !== 2'd2) begin errors++; $display("FAIL busy_cnt: got %0d, expected 2", e.cnt); end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (acc_cnt - a0 != 1) begin errors++; $display("FAIL busy_accepts: got %0d, expected 1", acc_cnt - a0); end
        check_rx("busy", 1);
    endtask

    task automatic test_back_to_back();
        logic [23:0] d[4];
        int          k[4];
        int          t;
        int          fd0;
        done_t       e;
        do_reset();
        fd0 = stray_fd;
        for (int i = 0; i < 4; i++) d[i] = 24'($urandom);
        @(negedge clk);
        pif.rgb_data    = d[0];
        pif.pixel_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t = 0;
            while (pif.pixel_ready !== 1'b1 && t < 300) begin
                @(negedge clk);
                t++;
            end
            k[i] = cyc;
            exp_q.push_back(d[i]);
            @(posedge clk);
            #1;
            if (i < 3) pif.rgb_data = d[i + 1];
            else       pif.pixel_valid = 1'b0;
            @(negedge clk);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (k[i] - k[i - 1] != c_pix_cyc) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d cycles, expected %0d", i, k[i] - k[i - 1], c_pix_cyc);
            end
        end
        wait_done(4);
        for (int i = 0; i < 4 && done_q.size() > 0; i++) begin
            e = done_q.pop_front();
            checks++;
            if (e.cyc != k[i] + c_pix_cyc || e.cnt !== 2'((i + 1) % 4) || e.fd !== (i == 3)) begin
                errors++;
                $display("FAIL b2b_done%0d: at k+%0d cnt=%0d fd=%b, expected k+%0d cnt=%0d fd=%b",
                         i, e.cyc - k[i], e.cnt, e.fd, c_pix_cyc, (i + 1) % 4, (i == 3));
            end
        end
        checks++;
        if (stray_fd != fd0) begin errors++; $display("FAIL b2b_stray_frame_done: got %0d, expected 0", stray_fd - fd0); end
        check_rx("b2b", 4);
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        send_pixel(24'h5AC3E1, k);
        while (cyc < k + 55) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || pif.pixel_ready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: tx=%b ready=%b busy=%b, expected 1/1/0", tx, pif.pixel_ready, tx_busy);
        end
        checks++;
        if (pixel_cnt !== 2'd0 || pixel_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_cnt: cnt=%0d done=%b, expected 0/0", pixel_cnt, pixel_done);
        end
        reset = 1'b0;
        checks++;
        if (done_q.size() != 0) begin errors++; $display("FAIL midreset_counted: got %0d completions, expected 0", done_q.size()); end
        send_pixel(24'hC0FFEE, k);
        watch_pixel("after_reset", k, 24'hC0FFEE, 2'd1);
        check_rx("after_reset", 1);
    endtask

    task automatic test_loopback();
        int    k;
        done_t e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send_pixel(24'($urandom), k);
        end
        wait_done(4);
        check_rx("loopback", 4);
        checks++;
        if (rx_frame_cnt != 1) begin errors++; $display("FAIL loopback_rx_frame: got %0d, expected 1", rx_frame_cnt); end
        if (done_q.size() == 4) begin
            e = done_q[3];
            checks++;
            if (e.fd !== 1'b1 || e.cnt !== 2'd0) begin
                errors++;
                $display("FAIL loopback_frame_done: fd=%b cnt=%0d, expected 1/0", e.fd, e.cnt);
            end
        end
    endtask

    initial begin
        pif.pixel_valid = 1'b0;
        pif.rgb_data    = '0;
        test_reset();
        test_single();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
